pipe_stage_reg: RTL
===================

// Module: pipe_stage_reg
// PURPOSE
//   Generic, parametrised pipeline stage register that replaces the per-stage hand-written
//   latches (IF/ID, ID/EX, EX/MEM, MEM/WB). Carries a control field and a data payload.
//   Adds a valid/ready handshake, stall back-pressure, flush and NOP-bubble insertion,
//   plus an optional 2-entry skid buffer that breaks the combinational ready path.
// PARAMETERS
//   CTRL_W  8   control bits (RegWrite, MemWr, ...); forced to 0 on bubble/flush/reset
//   DATA_W  96  payload bits (operands, imm, reg indices, funct); passed bit-exact
//   SKID    0   0 = single register (depth 1); 1 = main + skid register (depth 2)
// PORTS
//   clk_i         in   1       clock, all state updates on posedge
//   rst_i         in   1       synchronous reset, active-high
//   start_i       in   1       run enable; 0 freezes all state, in_ready_o=0, bubble_ack_o=0
//   flush_i       in   1       discard every held entry (branch taken / exception)
//   bubble_i      in   1       request insertion of one NOP entry (load-use hazard)
//   bubble_ack_o  out  1       bubble inserted this cycle; requester drops bubble_i next cycle
//   in_valid_i    in   1       upstream entry valid
//   in_ready_o    out  1       stage accepts upstream entry this cycle
//   in_ctrl_i     in   CTRL_W  upstream control field
//   in_data_i     in   DATA_W  upstream payload
//   out_valid_o   out  1       head entry valid
//   out_ready_i   in   1       downstream consumes head entry this cycle
//   out_ctrl_o    out  CTRL_W  head control field
//   out_data_o    out  DATA_W  head payload
//   occupancy_o   out  2       held entries, 0..(SKID+1)
// BEHAVIOUR
//   - Clock clk_i; reset rst_i is synchronous and active-high. Priority: rst_i > !start_i > flush_i > bubble_i > accept.
//   - Reset: out_valid_o=0, out_ctrl_o=0, out_data_o=0, occupancy_o=0, bubble_ack_o=0;
//     skid reg valid/ctrl/data=0; in_ready_o=start_i (combinational after reset).
//   - slot_free: SKID=0 -> (!main_v | out_ready_i); SKID=1 -> !skid_v (registered, no comb
//     path from out_ready_i).
//   - in_ready_o   = start_i & !flush_i & !bubble_i & slot_free.
//   - bubble_ack_o = start_i & !flush_i & bubble_i & slot_free. Bubble = valid entry, ctrl=0.
//   - Accept on in_valid_i & in_ready_o; drain on out_valid_o & out_ready_i. Latency 1 cycle
//     from accept to out_valid_o when stage empty. Strict FIFO order, no loss/duplication.
//   - Outputs always come from main reg. SKID=1: entry arriving while main is held
//     (main_v & !out_ready_i) goes to skid; on main drain, skid moves to main same edge.
//     Skid full -> in_ready_o=0 until main drains. Accept into empty main bypasses skid.
//   - Simultaneous drain+accept at occupancy 1: occupancy stays 1, new entry in main.
//   - flush_i (start_i=1): head still visible and consumable that cycle; next edge all valid=0,
//     all ctrl=0, occupancy_o=0; no accept, no bubble that cycle.
//   - start_i=0: full freeze, outputs hold, out_ready_i ignored (no drain counted).
//   - rst_i mid-stream: entries discarded, state = reset values at next edge.
//   - occupancy_o = main_v + skid_v; never exceeds SKID+1.
// CONFIGURATION
//   PIPE_STAGE_ZERO_DATA_EN defined: data fields also cleared to 0 on flush and bubble entries
//     carry data=0 (clean waveforms, X-free).
//   Not defined: flush clears only valid/ctrl, data regs hold last value; bubble entry
//     carries data=0 only at reset, otherwise prior main data. Reset always clears data.
// TESTING
//   1 SKID=0, stream 0x11,0x22,0x33 with out_ready_i=1 -> out_data_o same order, 1-cycle lag, occ<=1.
//   2 SKID=1, out_ready_i=0, push 0xA,0xB,0xC -> 0xA,0xB held, occ=2, in_ready_o=0 for 0xC;
//     release out_ready_i -> 0xA,0xB,0xC in order, none lost.
//   3 bubble_i=1 with stage empty -> bubble_ack_o=1, next cycle out_valid_o=1, out_ctrl_o=0,
//     in_ready_o=0 during bubble cycle; upstream entry accepted the cycle after.
//   4 occ=2, assert flush_i with in_valid_i=1 -> next cycle occ=0, out_valid_o=0, input not taken;
//     with PIPE_STAGE_ZERO_DATA_EN out_data_o=0.
//   5 start_i=0 for 3 cycles mid-stream -> outputs/occupancy frozen, resume exact order.
//   6 rst_i=1 at occ=2 -> next edge all outputs 0, occupancy_o=0, in_ready_o=1.

Source files
------------

// File: rtl/pipe_stage_reg.sv
// Parametrised pipeline stage register with valid/ready handshake, flush, NOP-bubble insertion
// and optional skid entry (SKID=1). Define PIPE_STAGE_ZERO_DATA_EN to zero data on flush/bubble.
module pipe_stage_reg #(
  parameter int unsigned CTRL_W = 8,
  parameter int unsigned DATA_W = 96,
  parameter int unsigned SKID   = 0
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              start_i,
  input  logic              flush_i,
  input  logic              bubble_i,
  output logic              bubble_ack_o,
  input  logic              in_valid_i,
  output logic              in_ready_o,
  input  logic [CTRL_W-1:0] in_ctrl_i,
  input  logic [DATA_W-1:0] in_data_i,
  output logic              out_valid_o,
  input  logic              out_ready_i,
  output logic [CTRL_W-1:0] out_ctrl_o,
  output logic [DATA_W-1:0] out_data_o,
  output logic [1:0]        occupancy_o
);

  logic              main_v_q, main_v_d;
  logic [CTRL_W-1:0] main_ctrl_q, main_ctrl_d;
  logic [DATA_W-1:0] main_data_q, main_data_d;
  logic              skid_v_q, skid_v_d;
  logic [CTRL_W-1:0] skid_ctrl_q, skid_ctrl_d;
  logic [DATA_W-1:0] skid_data_q, skid_data_d;

  logic              slot_free;
  logic              drain;
  logic              push;
  logic [CTRL_W-1:0] push_ctrl;
  logic [DATA_W-1:0] push_data;

  // With a skid entry, readiness depends only on registered state.
  assign slot_free    = (SKID != 0) ? !skid_v_q : (!main_v_q | out_ready_i);
  assign in_ready_o   = start_i & !flush_i & !bubble_i & slot_free;
  assign bubble_ack_o = start_i & !flush_i & bubble_i & slot_free;
  assign drain        = start_i & main_v_q & out_ready_i;
  assign push         = (in_valid_i & in_ready_o) | bubble_ack_o;
  assign push_ctrl    = bubble_ack_o ? '0 : in_ctrl_i;
`ifdef PIPE_STAGE_ZERO_DATA_EN
  assign push_data    = bubble_ack_o ? '0 : in_data_i;
`else
  assign push_data    = bubble_ack_o ? main_data_q : in_data_i;
`endif

  // Next-state: flush wipes everything; otherwise drain first, then place the new entry.
  always_comb begin
    main_v_d    = main_v_q;
    main_ctrl_d = main_ctrl_q;
    main_data_d = main_data_q;
    skid_v_d    = skid_v_q;
    skid_ctrl_d = skid_ctrl_q;
    skid_data_d = skid_data_q;
    if (start_i) begin
      if (flush_i) begin
        main_v_d    = 1'b0;
        main_ctrl_d = '0;
        skid_v_d    = 1'b0;
        skid_ctrl_d = '0;
`ifdef PIPE_STAGE_ZERO_DATA_EN
        main_data_d = '0;
        skid_data_d = '0;
`endif
      end else begin
        if (drain) begin
          if (skid_v_q) begin
            main_v_d    = 1'b1;
            main_ctrl_d = skid_ctrl_q;
            main_data_d = skid_data_q;
            skid_v_d    = 1'b0;
          end else begin
            main_v_d = 1'b0;
          end
        end
        if (push) begin
          if (!main_v_q || drain) begin
            main_v_d    = 1'b1;
            main_ctrl_d = push_ctrl;
            main_data_d = push_data;
          end else begin
            skid_v_d    = 1'b1;
            skid_ctrl_d = push_ctrl;
            skid_data_d = push_data;
          end
        end
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      main_v_q    <= 1'b0;
      main_ctrl_q <= '0;
      main_data_q <= '0;
      skid_v_q    <= 1'b0;
      skid_ctrl_q <= '0;
      skid_data_q <= '0;
    end else begin
      main_v_q    <= main_v_d;
      main_ctrl_q <= main_ctrl_d;
      main_data_q <= main_data_d;
      skid_v_q    <= skid_v_d;
      skid_ctrl_q <= skid_ctrl_d;
      skid_data_q <= skid_data_d;
    end
  end

  assign out_valid_o = main_v_q;
  assign out_ctrl_o  = main_ctrl_q;
  assign out_data_o  = main_data_q;
  assign occupancy_o = {1'b0, main_v_q} + {1'b0, skid_v_q};

endmodule
